// File: rtl/wb_line_mem_adaptor.sv
// -----------------------------------------------------------------------------
// wb_line_mem_adaptor
//
// Wishbone slave that turns one 128-bit cache-line request into a fixed
// 4-beat burst of 32-bit beats on a req/gnt + rvalid memory port.
//   - Reads: the four returned beats are collected into per-beat slot
//     registers. The assembled line is presented on wb_dat_s with a one-cycle
//     wb_ack.
//   - Writes: the captured line and byte enables are sliced into beats. The
//     request completes once beat 3 is granted, because no write response
//     comes back from memory.
//   - A beat error, or a stall lasting TIMEOUT cycles, completes the request
//     with a one-cycle wb_rty instead of wb_ack.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wb_cyc/stb/we         Wishbone cycle, strobe, line write select
//   wb_sel[15:0]          line byte enables (beat i uses [4i+3:4i])
//   wb_adr[ADDR_W-1:0]    line byte address (bits [3:0] ignored)
//   wb_dat_m[127:0]       write line
//   wb_dat_s[127:0]       registered read line, held until next read completes
//   wb_ack, wb_rty        one-cycle completion / retry
//   mem_req/we/addr/be/wdata  beat request, valid until mem_gnt
//   mem_gnt               beat accepted when mem_req & mem_gnt
//   mem_rvalid/rdata      in-order read beat return
//   mem_err               beat failed (qualified by rvalid on reads, gnt on writes)
// -----------------------------------------------------------------------------

// One read-data slot of the line. o_slot_nxt forwards a beat that is loaded
// this cycle, so the completed line can be registered on the same edge that
// the last beat arrives.
module wb_line_mem_lane (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [31:0] i_data,
   output logic [31:0] o_slot_nxt
);
   logic [31:0] r_slot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_slot <= '0;
      else if (i_load) r_slot <= i_data;
   end

   assign o_slot_nxt = i_load ? i_data : r_slot;
endmodule

module wb_line_mem_adaptor #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   // Wishbone slave
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [15:0]       wb_sel,
   input  logic [ADDR_W-1:0] wb_adr,
   input  logic [127:0]      wb_dat_m,
   output logic [127:0]      wb_dat_s,
   output logic              wb_ack,
   output logic              wb_rty,
   // memory beat port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_err
);
   localparam int NUM_BEATS = 4;
   localparam int BEAT_W    = 32;
   localparam int TCNT_W    = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RESP,
      S_HOLD
   } state_t;

   state_t r_state, w_state_nxt;

   // captured request
   logic [ADDR_W-5:0]                  r_adr_hi;
   logic                               r_we;
   logic [NUM_BEATS-1:0][3:0]          r_sel;
   logic [NUM_BEATS-1:0][BEAT_W-1:0]   r_dat;

   // burst progress; bit 2 of each counter marks "all four done"
   logic [2:0]                         r_req_cnt;
   logic [2:0]                         r_rsp_cnt;
   logic [TCNT_W-1:0]                  r_tcnt;
   logic                               r_err;
   logic                               r_tmo;
   logic                               r_abort;

   logic [127:0]                       r_dat_s;
   logic [NUM_BEATS-1:0][BEAT_W-1:0]   w_line_nxt;

   logic w_cap, w_busy, w_req, w_gnt, w_rv, w_prog;
   logic w_tmo_hit, w_rd_done, w_wr_done, w_beat_err, w_resp_ok;

   // Line offset bits are don't-care on the Wishbone side.
   logic w_unused;
   assign w_unused = &{1'b0, wb_adr[3:0]};

   // ---------------------------------------------------------------------------
   // Per-cycle events
   // ---------------------------------------------------------------------------
   assign w_cap  = (r_state == S_IDLE) && wb_cyc && wb_stb;
   assign w_busy = (r_state == S_RD) || (r_state == S_WR);
   assign w_req  = w_busy && !r_req_cnt[2];
   assign w_gnt  = w_req && mem_gnt;
   // Returns are only accepted while the read is live. This is what discards
   // stragglers after a timeout.
   assign w_rv   = (r_state == S_RD) && mem_rvalid && !r_rsp_cnt[2];
   assign w_prog = w_gnt || w_rv;

   assign w_tmo_hit  = w_busy && !w_prog && (r_tcnt == TCNT_W'(TIMEOUT - 1));
   assign w_rd_done  = w_rv && (r_rsp_cnt == 3'd3);
   assign w_wr_done  = (r_state == S_WR) && w_gnt && (r_req_cnt == 3'd3);
   assign w_beat_err = (w_rv && mem_err) || ((r_state == S_WR) && w_gnt && mem_err);

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_cap)                  w_state_nxt = wb_we ? S_WR : S_RD;
         S_RD:   if (w_rd_done || w_tmo_hit) w_state_nxt = S_RESP;
         S_WR:   if (w_wr_done || w_tmo_hit) w_state_nxt = S_RESP;
         S_RESP:                             w_state_nxt = S_HOLD;
         // HOLD lets the master drop its strobe before the next capture.
         S_HOLD:                             w_state_nxt = S_IDLE;
         default:                            w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Request capture and burst bookkeeping
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_adr_hi  <= '0;
         r_we      <= 1'b0;
         r_sel     <= '0;
         r_dat     <= '0;
         r_req_cnt <= '0;
         r_rsp_cnt <= '0;
         r_tcnt    <= '0;
         r_err     <= 1'b0;
         r_tmo     <= 1'b0;
         r_abort   <= 1'b0;
         r_dat_s   <= '0;
      end else if (w_cap) begin
         r_adr_hi  <= wb_adr[ADDR_W-1:4];
         r_we      <= wb_we;
         r_sel     <= wb_sel;
         r_dat     <= wb_dat_m;
         r_req_cnt <= '0;
         r_rsp_cnt <= '0;
         r_tcnt    <= '0;
         r_err     <= 1'b0;
         r_tmo     <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         if (w_gnt)      r_req_cnt <= r_req_cnt + 3'd1;
         if (w_rv)       r_rsp_cnt <= r_rsp_cnt + 3'd1;
         if (w_beat_err) r_err     <= 1'b1;
         if (w_tmo_hit)  r_tmo     <= 1'b1;
         // The master walked away. The burst still drains on the memory
         // side, but nobody is listening for the response.
         if (w_busy && !wb_cyc) r_abort <= 1'b1;
         if (w_busy)     r_tcnt    <= w_prog ? '0 : r_tcnt + TCNT_W'(1);
         if (w_rd_done)  r_dat_s   <= w_line_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Read slots, one per beat, filled in return order
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < NUM_BEATS; g++) begin : g_lane
      wb_line_mem_lane u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_load     (w_rv && (r_rsp_cnt[1:0] == 2'(g))),
         .i_data     (mem_rdata),
         .o_slot_nxt (w_line_nxt[g])
      );
   end

   // ---------------------------------------------------------------------------
   // Outputs. These are decoded from registered state, so an asynchronous reset
   // forces them to zero immediately.
   // ---------------------------------------------------------------------------
   assign mem_req   = w_req;
   assign mem_we    = w_req && r_we;
   assign mem_addr  = w_req ? {r_adr_hi, r_req_cnt[1:0], 2'b00} : '0;
   assign mem_be    = w_req ? r_sel[r_req_cnt[1:0]] : 4'h0;
   assign mem_wdata = (w_req && r_we) ? r_dat[r_req_cnt[1:0]] : 32'h0;

   assign w_resp_ok = (r_state == S_RESP) && wb_cyc && !r_abort;
   assign wb_ack    = w_resp_ok && !(r_err || r_tmo);
   assign wb_rty    = w_resp_ok &&  (r_err || r_tmo);
   assign wb_dat_s  = r_dat_s;

endmodule

// File: tb/tb_wb_line_mem_adaptor.sv
// -----------------------------------------------------------------------------
// Directed bench for wb_line_mem_adaptor (TIMEOUT = 16).
// A small in-line memory responder grants beats, returns read data one cycle
// after each read grant, and can stall, fail or withhold grants on request.
// Inputs are driven 1 time unit after the rising edge. Outputs are observed
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_line_mem_adaptor;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [15:0]       wb_sel = '0;
   logic [ADDR_W-1:0] wb_adr = '0;
   logic [127:0]      wb_dat_m = '0;
   logic [127:0]      wb_dat_s;
   logic              wb_ack, wb_rty;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
   logic [31:0]       mem_rdata = '0;

   always #5 clk = ~clk;

   wb_line_mem_adaptor #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
      .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
      .wb_ack(wb_ack), .wb_rty(wb_rty),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   int n_vec = 0, n_err = 0;
   int cyc = 0, cap = 0;
   int n_gnt, rv_idx, ack_cnt, rty_cnt, both_cnt, ack_at, rty_at, req_cyc;
   int stall_beat = 0, stall_left = 0, err_beat = -1;
   bit gnt_off = 1'b0, rv_pend = 1'b0;
   logic [31:0] rd_tab [4];
   logic [31:0] log_addr [8];
   logic [31:0] log_wd [8];
   logic [3:0]  log_be [8];
   logic        log_we [8];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive responder inputs, observe at the falling edge,
   // then advance to 1 unit past the next rising edge.
   task automatic cycle();
      mem_gnt    = !gnt_off && !(stall_left > 0 && n_gnt == stall_beat);
      mem_rvalid = rv_pend;
      mem_rdata  = (rv_pend && rv_idx < 4) ? rd_tab[rv_idx] : 32'h0;
      mem_err    = rv_pend && (rv_idx == err_beat);
      @(negedge clk);
      if (mem_req) req_cyc++;
      if (mem_req && mem_gnt) begin
         if (n_gnt < 8) begin
            log_addr[n_gnt] = mem_addr;
            log_wd[n_gnt]   = mem_wdata;
            log_be[n_gnt]   = mem_be;
            log_we[n_gnt]   = mem_we;
         end
         n_gnt++;
      end else if (mem_req && stall_left > 0 && n_gnt == stall_beat) begin
         stall_left--;
      end
      rv_pend = mem_req && mem_gnt && !mem_we;
      if (mem_rvalid) rv_idx++;
      if (wb_ack) begin ack_cnt++; ack_at = cyc; end
      if (wb_rty) begin rty_cnt++; rty_at = cyc; end
      if (wb_ack && wb_rty) both_cnt++;
      @(posedge clk); #1;
      cyc++;
   endtask

   // Present a request for one cycle. The capture edge ends that cycle.
   // Afterwards the bus is scrambled, because the adaptor must not look at it again.
   task automatic start_req(input logic we, input logic [31:0] adr,
                            input logic [15:0] sel, input logic [127:0] dat);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
      wb_adr = adr;  wb_sel = sel;  wb_dat_m = dat;
      n_gnt = 0; rv_idx = 0; rv_pend = 1'b0; req_cyc = 0;
      ack_cnt = 0; rty_cnt = 0; both_cnt = 0; ack_at = -1; rty_at = -1;
      cycle();
      cap = cyc;
      wb_adr = 32'hFFFF_FFF0; wb_we = ~we; wb_sel = 16'h0; wb_dat_m = '0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && (ack_cnt + rty_cnt) == 0; i++) cycle();
      chk("resp_within_budget", ack_cnt + rty_cnt, 1);
   endtask

   // The request stays asserted through HOLD and must not be taken again.
   task automatic hold_idle();
      int r0, d0;
      r0 = req_cyc; d0 = ack_cnt + rty_cnt;
      cycle();
      wb_cyc = 1'b0; wb_stb = 1'b0;
      cycle();
      chk("hold_no_recapture", req_cyc - r0, 0);
      chk("single_resp_pulse", ack_cnt + rty_cnt - d0, 0);
   endtask

   localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] LINE_C = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
   localparam logic [127:0] WLINE  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

   initial begin
      rd_tab[0] = 32'h11111111; rd_tab[1] = 32'h22222222;
      rd_tab[2] = 32'h33333333; rd_tab[3] = 32'h44444444;

      // ---- reset state ----
      #12;
      chk("rst_mem_req",   mem_req,   0);
      chk("rst_mem_we",    mem_we,    0);
      chk("rst_mem_addr",  mem_addr,  0);
      chk("rst_mem_be",    mem_be,    0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wb_ack",    wb_ack,    0);
      chk("rst_wb_rty",    wb_rty,    0);
      chk("rst_wb_dat_s",  wb_dat_s,  0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // ---- line read, gnt always, rvalid one cycle after gnt ----
      start_req(1'b0, 32'h0000_1238, 16'hFFFF, '0);
      wait_done(20);
      chk("rd_ack",       ack_cnt, 1);
      chk("rd_no_rty",    rty_cnt, 0);
      chk("rd_ack_cycle", ack_at - cap, 5);   // ACK high in the cycle ending at capture+6
      chk("rd_beats",     n_gnt, 4);
      chk("rd_we",        log_we[0], 0);
      chk("rd_addr0",     log_addr[0], 32'h1230);
      chk("rd_addr1",     log_addr[1], 32'h1234);
      chk("rd_addr2",     log_addr[2], 32'h1238);
      chk("rd_addr3",     log_addr[3], 32'h123C);
      chk("rd_line",      wb_dat_s, LINE_A);
      hold_idle();

      // ---- line write, beat 1 stalled for two cycles ----
      stall_beat = 1; stall_left = 2;
      start_req(1'b1, 32'h0000_0040, 16'h0F0F, WLINE);
      wait_done(20);
      chk("wr_ack",       ack_cnt, 1);
      chk("wr_no_rty",    rty_cnt, 0);
      chk("wr_ack_cycle", ack_at - cap, 6);
      chk("wr_beats",     n_gnt, 4);
      chk("wr_we",        log_we[3], 1);
      chk("wr_addr0",     log_addr[0], 32'h40);
      chk("wr_addr1",     log_addr[1], 32'h44);
      chk("wr_addr2",     log_addr[2], 32'h48);
      chk("wr_addr3",     log_addr[3], 32'h4C);
      chk("wr_be0",       log_be[0], 4'hF);
      chk("wr_be1",       log_be[1], 4'h0);
      chk("wr_be2",       log_be[2], 4'hF);
      chk("wr_be3",       log_be[3], 4'h0);
      chk("wr_data0",     log_wd[0], 32'hAAAAAAAA);
      chk("wr_data1",     log_wd[1], 32'hBBBBBBBB);
      chk("wr_data2",     log_wd[2], 32'hCCCCCCCC);
      chk("wr_data3",     log_wd[3], 32'hDDDDDDDD);
      chk("wr_keeps_rd_line", wb_dat_s, LINE_A);
      hold_idle();

      // ---- read with an error on beat 2 ----
      err_beat = 2;
      start_req(1'b0, 32'h0000_0100, 16'hFFFF, '0);
      wait_done(20);
      chk("err_rty",       rty_cnt, 1);
      chk("err_no_ack",    ack_cnt, 0);
      chk("err_rty_cycle", rty_at - cap, 5);
      chk("err_all_beats", rv_idx, 4);
      chk("err_not_both",  both_cnt, 0);
      hold_idle();

      // ---- clean read after error: flag cleared, new line returned ----
      err_beat = -1;
      rd_tab[0] = 32'hCAFE0000; rd_tab[1] = 32'hCAFE0001;
      rd_tab[2] = 32'hCAFE0002; rd_tab[3] = 32'hCAFE0003;
      start_req(1'b0, 32'h0000_2000, 16'hFFFF, '0);
      wait_done(20);
      chk("clean_ack",    ack_cnt, 1);
      chk("clean_no_rty", rty_cnt, 0);
      chk("clean_line",   wb_dat_s, LINE_C);
      hold_idle();

      // ---- wb_cyc dropped after beat 1 is granted ----
      start_req(1'b0, 32'h0000_0300, 16'hFFFF, '0);
      cycle(); cycle();
      chk("abort_two_granted", n_gnt, 2);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      repeat (8) cycle();
      chk("abort_beats",  n_gnt, 4);
      chk("abort_addr3",  log_addr[3], 32'h30C);
      chk("abort_no_ack", ack_cnt, 0);
      chk("abort_no_rty", rty_cnt, 0);
      chk("abort_req_cycles", req_cyc, 4);

      // ---- timeout: no grant ever ----
      gnt_off = 1'b1;
      start_req(1'b0, 32'h0000_0400, 16'hFFFF, '0);
      wait_done(40);
      chk("tmo_rty",        rty_cnt, 1);
      chk("tmo_no_ack",     ack_cnt, 0);
      chk("tmo_rty_cycle",  rty_at - cap, 16);
      chk("tmo_req_cycles", req_cyc, 16);
      hold_idle();
      gnt_off = 1'b0;

      // ---- asynchronous reset in the third cycle of a read ----
      rd_tab[0] = 32'h11111111; rd_tab[1] = 32'h22222222;
      rd_tab[2] = 32'h33333333; rd_tab[3] = 32'h44444444;
      start_req(1'b0, 32'h0000_0080, 16'hFFFF, '0);
      cycle(); cycle();
      chk("rst_mid_req_before", mem_req, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_req",   mem_req,  0);
      chk("rst_mid_ack",   wb_ack,   0);
      chk("rst_mid_addr",  mem_addr, 0);
      chk("rst_mid_dat_s", wb_dat_s, 0);
      wb_cyc = 1'b0; wb_stb = 1'b0; rv_pend = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      start_req(1'b0, 32'h0000_0200, 16'hFFFF, '0);
      wait_done(20);
      chk("post_rst_ack",       ack_cnt, 1);
      chk("post_rst_ack_cycle", ack_at - cap, 5);
      chk("post_rst_addr0",     log_addr[0], 32'h200);
      chk("post_rst_line",      wb_dat_s, LINE_A);
      hold_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/wb_line_mem_adaptor.md
Name: wb_line_mem_adaptor

Overview:
- Wishbone slave that sits directly downstream of the cache-arbiter interconnect, in the `dram` slot.
- Converts each 128-bit cache-line request into a 4-beat burst of 32-bit transactions on a simple req/gnt + rvalid memory port.
- Read lines are reassembled and returned with a single-cycle ACK; write lines are split into beats, with byte enables taken from SEL.
- Memory errors and stalls are reported as a single-cycle RTY, so the caches re-issue the request.

Parameters:
ADDR_W, 32, width of byte address on both sides
TIMEOUT, 1024, cycles without memory progress before the request is abandoned with RTY (must be >= 16)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wb_cyc  in  1  Wishbone cycle valid
wb_stb  in  1  Wishbone strobe
wb_we  in  1  1 = line write, 0 = line read
wb_sel  in  16  byte enables for the 128-bit line
wb_adr  in  ADDR_W  byte address; bits [3:0] ignored (line aligned)
wb_dat_m  in  128  write line data
wb_dat_s  out  128  read line data
wb_ack  out  1  single-cycle completion
wb_rty  out  1  single-cycle retry/error
mem_req  out  1  beat request valid
mem_we  out  1  beat write
mem_addr  out  ADDR_W  beat byte address
mem_be  out  4  beat byte enables
mem_wdata  out  32  beat write data
mem_gnt  in  1  beat accepted when mem_req & mem_gnt
mem_rvalid  in  1  read beat returned; in request order
mem_rdata  in  32  read beat data
mem_err  in  1  qualified by mem_rvalid (read) or mem_gnt (write); beat failed

Behaviour:
- Reset (rst_n=0, async): state=IDLE, counters=0, err flag=0. Outputs: wb_ack=0, wb_rty=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, wb_dat_s=0.
- Beat i (i=0..3) mapping:
  - address = {wb_adr[ADDR_W-1:4], i[1:0], 2'b00}
  - data = line bits [32i+31:32i]
  - be = wb_sel[4i+3:4i]
  - Little-endian; beats are always issued in order 0..3.
- Request capture: adr/we/sel/dat_m are registered in IDLE when wb_cyc & wb_stb; the Wishbone inputs are ignored afterwards.
- States:
  - IDLE: on wb_cyc & wb_stb, capture the request and go to RD (we=0) or WR (we=1).
  - RD:
    - Drives mem_req=1, mem_we=0, beat req_cnt; req_cnt advances on mem_gnt.
    - Each mem_rvalid writes mem_rdata into slot rsp_cnt and increments rsp_cnt. Issue and return overlap.
    - A beat may return in the same cycle it is granted.
    - mem_req deasserts after beat 3 is granted.
    - When the 4th rvalid is received, go to RESP.
  - WR:
    - Drives mem_req=1, mem_we=1 with beat data/be; req_cnt advances on mem_gnt.
    - Beats with be=0 are still issued (fixed 4 beats).
    - When beat 3 is granted, go to RESP. No write response is expected.
  - RESP: for exactly one cycle, wb_ack=1 (or wb_rty=1 if the err flag is set or a timeout occurred), wb_dat_s holds the assembled line for reads. Then go to HOLD.
  - HOLD: one dead cycle so the same still-asserted request is not re-accepted. Then go to IDLE.
- Latency: with mem_gnt tied high and rvalid one cycle after gnt, read ACK comes 6 cycles after the capture edge; write ACK comes 5 cycles after.
- wb_dat_s is registered and held stable from RESP until the next read completes.
- mem_err:
  - Sets a sticky err flag; the burst still completes all 4 beats (no cancel).
  - The flag is cleared on capture.
- Timeout:
  - A counter resets on every gnt or rvalid.
  - Reaching TIMEOUT in RD/WR forces RESP with wb_rty=1 and drops mem_req.
  - Late rvalids after that point are ignored until the next capture.
- wb_cyc dropping mid-burst: the burst still completes on the memory side; RESP then asserts neither ACK nor RTY.
- wb_ack and wb_rty are never asserted together, and never asserted outside RESP.
- Reset asserted mid-burst: immediate return to IDLE with outputs at their reset values. Outstanding memory beats are not tracked.

Test Plan:
- Read, gnt=1, rvalid 1 cycle later, adr=0x0000_1238, rdata beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C; wb_dat_s=0x44444444_33333333_22222222_11111111; single wb_ack at capture+6.
- Write, adr=0x40, sel=0x0F0F, dat_m=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, gnt stalled 2 cycles on beat 1 -> 4 beats with be 0xF, 0x0, 0xF, 0x0; data AAAA.., BBBB.., CCCC.., DDDD..; addr 0x40..0x4C; single wb_ack after beat 3 is granted; no re-capture during HOLD while stb stays high.
- Read with mem_err on beat 2 -> all 4 beats consumed; wb_rty=1 for one cycle; wb_ack stays 0; the next clean read returns wb_ack.
- TIMEOUT=16, read with mem_gnt held 0 -> wb_rty pulse at the 16th idle cycle; mem_req low afterwards; back to IDLE 2 cycles later.
- wb_cyc dropped after beat 1 is granted -> beats 2-3 still issued; no ACK/RTY pulse; IDLE after HOLD.
- rst_n asserted in cycle 3 of a read -> mem_req=0 and wb_ack=0 immediately (asynchronous); a new request after reset release completes normally.
